// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier controller that stalls the pipeline while a MUL is in flight.
// Optional MUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are all zero.
module mul_seq_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   input  logic [4:0]        rd_addr_i,
   input  logic              kill_i,
   output logic              stall_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o,
   output logic [4:0]        rd_addr_o
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [4:0]        rd_addr_q, rd_addr_d;
   logic [4:0]        rd_out_q, rd_out_d;
   logic              last_step;

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      result_d  = result_q;
      count_d   = count_q;
      rd_addr_d = rd_addr_q;
      rd_out_d  = rd_out_q;
      last_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_i && !kill_i) begin
               state_d   = RUN;
               mcand_d   = op_a_i;
               mplier_d  = op_b_i;
               rd_addr_d = rd_addr_i;
               acc_d     = '0;
               count_d   = '0;
            end
         end
         RUN: begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CNT_W'(1);
            if (count_q == CNT_W'(DATA_W - 1)) last_step = 1'b1;
`ifdef MUL_EARLY_EXIT_EN
            if (mplier_d == '0) last_step = 1'b1;
`endif
            // Output registers only change on entry to DONE so they hold between results.
            if (last_step) begin
               state_d  = DONE;
               result_d = acc_d;
               rd_out_d = rd_addr_q;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (kill_i) begin
         state_d  = IDLE;
         result_d = result_q;
         rd_out_d = rd_out_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         result_q  <= '0;
         count_q   <= '0;
         rd_addr_q <= '0;
         rd_out_q  <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         count_q   <= count_d;
         rd_addr_q <= rd_addr_d;
         rd_out_q  <= rd_out_d;
      end
   end

   assign stall_o   = ((state_q == IDLE) && valid_i && !kill_i) || (state_q == RUN);
   assign busy_o    = (state_q == RUN);
   assign done_o    = (state_q == DONE);
   assign result_o  = result_q;
   assign rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: expected product, destination and latency are queued at
// issue and compared when done_o pulses. Honours MUL_EARLY_EXIT_EN for the latency model.
module tb_mul_seq_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic [4:0]  rd_addr_i;
   logic        kill_i;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   mul_seq_ctrl dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .op_a_i    (op_a_i),
      .op_b_i    (op_b_i),
      .rd_addr_i (rd_addr_i),
      .kill_i    (kill_i),
      .stall_o   (stall_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .result_o  (result_o),
      .rd_addr_o (rd_addr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int exp_lat(input logic [31:0] b);
      int hi;
      hi = 0;
`ifdef MUL_EARLY_EXIT_EN
      for (int i = 0; i < 32; i++) if (b[i]) hi = i;
      return hi + 2;
`else
      return 33 + hi;
`endif
   endfunction

   // Issue one MUL in the current IDLE cycle and follow it to done_o; returns in the IDLE cycle after.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic hold);
      exp_t e;
      int   c;
      logic bad;
      e.res = a * b;
      e.rd  = rd;
      e.lat = exp_lat(b);
      sb.push_back(e);
      op_a_i    = a;
      op_b_i    = b;
      rd_addr_i = rd;
      valid_i   = 1'b1;
      #1;
      check_eq("stall_accept", stall_o, 1);
      c   = 0;
      bad = 1'b0;
      while (1) begin
         step();
         c++;
         if (done_o || c >= 100) break;
         if (!stall_o || !busy_o) bad = 1'b1;
      end
      check_eq("done_seen", done_o, 1);
      e = sb.pop_front();
      check_eq("latency", c, e.lat);
      check_eq("result", result_o, e.res);
      check_eq("rd_addr", rd_addr_o, e.rd);
      check_eq("stall_done", stall_o, 0);
      check_eq("busy_done", busy_o, 0);
      check_eq("stall_busy_run", bad, 0);
      valid_i = hold;
      step();
      check_eq("busy_after", busy_o, 0);
      check_eq("done_after", done_o, 0);
      if (hold) check_eq("stall_idle_hold", stall_o, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic saw_done;
      rst_i = 1'b0; valid_i = 1'b0; kill_i = 1'b0;
      op_a_i = '0; op_b_i = '0; rd_addr_i = '0;
      step();
      step();
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_done", done_o, 0);
      check_eq("rst_stall", stall_o, 0);
      check_eq("rst_result", result_o, 0);
      check_eq("rst_rd", rd_addr_o, 0);
      rst_i = 1'b1;
      step();

      run_mul(32'd7, 32'd6, 5'd5, 1'b0);
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b0);
      run_mul(32'h8000_0000, 32'd2, 5'd1, 1'b0);
      run_mul(32'd123, 32'd0, 5'd2, 1'b0);
      run_mul(32'd9, 32'd3, 5'd3, 1'b0);
      run_mul(32'd77, 32'd1, 5'd4, 1'b0);

      // Kill in IDLE beats valid.
      op_a_i = 32'd3; op_b_i = 32'd3; valid_i = 1'b1; kill_i = 1'b1;
      #1;
      check_eq("kill_idle_stall", stall_o, 0);
      step();
      check_eq("kill_idle_busy", busy_o, 0);
      kill_i = 1'b0; valid_i = 1'b0;
      step();

      // Kill at RUN cycle 10, then a new MUL right away.
      op_a_i = 32'd11; op_b_i = 32'hFFFF_FFFF; rd_addr_i = 5'd9; valid_i = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check_eq("run10_busy", busy_o, 1);
      kill_i = 1'b1;
      step();
      kill_i = 1'b0; valid_i = 1'b0;
      #1;
      check_eq("kill_run_busy", busy_o, 0);
      check_eq("kill_run_stall", stall_o, 0);
      check_eq("kill_run_done", done_o, 0);
      check_eq("kill_hold_rd", rd_addr_o, 5'd4);
      run_mul(32'd13, 32'd17, 5'd12, 1'b0);
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (done_o) saw_done = 1'b1;
      end
      check_eq("no_spurious_done", saw_done, 0);

      // Back-to-back with valid held through DONE.
      run_mul(32'd100, 32'd200, 5'd7, 1'b1);
      run_mul(32'hDEAD_BEEF, 32'h0000_0F0F, 5'd8, 1'b1);
      run_mul(32'h1234_5678, 32'h8765_4321, 5'd10, 1'b0);

      for (int i = 0; i < 4; i++)
         run_mul($urandom, $urandom, 5'($urandom_range(0, 31)), 1'b0);

      // Reset at RUN cycle 20.
      op_a_i = 32'd5; op_b_i = 32'hF000_0000; rd_addr_i = 5'd21; valid_i = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check_eq("run20_busy", busy_o, 1);
      rst_i = 1'b0; valid_i = 1'b0; kill_i = 1'b0;
      step();
      check_eq("mid_rst_busy", busy_o, 0);
      check_eq("mid_rst_stall", stall_o, 0);
      check_eq("mid_rst_done", done_o, 0);
      check_eq("mid_rst_result", result_o, 0);
      check_eq("mid_rst_rd", rd_addr_o, 0);
      rst_i = 1'b1;
      step();
      run_mul(32'd21, 32'd2, 5'd30, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
